// File: rtl/kuuga_bram_arbiter_if.sv
// kuuga_bram_arbiter_if: requester, response and BRAM-side signals of the shared BRAM port.
interface kuuga_bram_arbiter_if #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int WA_W = ADDR_WIDTH - $clog2(BE_W);
    logic [NUM_CH-1:0]            req_valid;
    logic [NUM_CH-1:0]            req_ready;
    logic [NUM_CH-1:0]            req_we;
    logic [NUM_CH*BE_W-1:0]       req_be;
    logic [NUM_CH*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CH*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_CH-1:0]            rsp_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] rsp_rdata;
    logic [NUM_CH-1:0]            misalign_err;
    logic                         mem_en;
    logic [BE_W-1:0]              mem_we;
    logic [WA_W-1:0]              mem_addr;
    logic [DATA_WIDTH-1:0]        mem_wdata;
    logic [DATA_WIDTH-1:0]        mem_rdata;

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, misalign_err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, misalign_err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/kuuga_bram_arbiter.sv
// kuuga_bram_arbiter: round-robin share of one read-first single-port BRAM among NUM_CH requesters,
// with a channel-tag pipeline that routes every access's response back to its requester.
module kuuga_bram_arbiter #(
    parameter int NUM_CH       = 2,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input logic                 clk,
    input logic                 reset,
    kuuga_bram_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int WA_W  = ADDR_WIDTH - OFF_W;
    localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int CW1   = CH_W + 1;
    localparam int NP    = 1 << CH_W;

    logic [CH_W-1:0]                   last;
    logic [CH_W-1:0]                   win;
    logic [CW1-1:0]                    cand;
    logic [NP-1:0]                     vld;
    logic                              any;
    logic [NUM_CH-1:0]                 grant;
    logic                              win_we;
    logic [BE_W-1:0]                   win_be;
    logic [ADDR_WIDTH-1:0]             win_addr;
    logic [DATA_WIDTH-1:0]             win_wdata;
    logic                              misaligned;
    logic [READ_LATENCY-1:0]           tag_v;
    logic [READ_LATENCY-1:0][CH_W-1:0] tag_ch;
    logic [NUM_CH-1:0]                 hit;
    logic [NUM_CH-1:0]                 rsp_v;
    logic [NUM_CH-1:0]                 err;
    logic [NUM_CH*DATA_WIDTH-1:0]      rsp_d;

    // Search last+1, last+2, ... wrapping at NUM_CH; vld is padded so every CH_W-bit index is legal.
    always_comb begin
        vld  = NP'(bus.req_valid);
        any  = 1'b0;
        win  = '0;
        cand = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = {1'b0, last} + CW1'(k);
            cand = cand >= CW1'(NUM_CH) ? cand - CW1'(NUM_CH) : cand;
            if (!any && vld[cand[CH_W-1:0]]) begin
                any = 1'b1;
                win = cand[CH_W-1:0];
            end
        end
    end

    assign grant = any ? NUM_CH'(1) << win : '0;

    always_comb begin
        win_we    = 1'b0;
        win_be    = '0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (grant[i]) begin
                win_we    = bus.req_we[i];
                win_be    = bus.req_be[i*BE_W +: BE_W];
                win_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
    end

    assign misaligned = (win_addr & ADDR_WIDTH'(BE_W - 1)) != '0;

    assign bus.req_ready    = grant;
    assign bus.mem_en       = any;
    assign bus.mem_we       = any && win_we ? win_be : '0;
    assign bus.mem_addr     = WA_W'(win_addr >> OFF_W);
    assign bus.mem_wdata    = win_wdata;
    assign bus.rsp_valid    = rsp_v;
    assign bus.rsp_rdata    = rsp_d;
    assign bus.misalign_err = err;

    // The last tag stage lines up with mem_rdata; the response registers form the final stage.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++)
            hit[i] = tag_v[READ_LATENCY-1] && tag_ch[READ_LATENCY-1] == CH_W'(i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last   <= CH_W'(NUM_CH - 1);
            tag_v  <= '0;
            tag_ch <= '0;
            rsp_v  <= '0;
            rsp_d  <= '0;
            err    <= '0;
        end else begin
            if (any)
                last <= win;
            tag_v[0]  <= any;
            tag_ch[0] <= win;
            for (int s = 1; s < READ_LATENCY; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_ch[s] <= tag_ch[s-1];
            end
            rsp_v <= hit;
            for (int i = 0; i < NUM_CH; i++)
                if (hit[i])
                    rsp_d[i*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rdata;
            if (misaligned)
                err <= err | grant;
        end
    end
endmodule

// File: tb/tb_kuuga_bram_arbiter.sv
// tb_kuuga_bram_arbiter: arbiters with READ_LATENCY 1 and 3 driving bench BRAMs; the latency-1
// instance is checked every cycle against a request/response model, both get directed checks.
module tb_kuuga_bram_arbiter;
    localparam int N = 2, AW = 16, DW = 32, WORDS = 1 << 14;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    kuuga_bram_arbiter_if #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();
    kuuga_bram_arbiter_if #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b3 ();

    kuuga_bram_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1))
        d1 (.clk(clk), .reset(reset), .bus(b1));
    kuuga_bram_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3))
        d3 (.clk(clk), .reset(reset), .bus(b3));

    // Read-first BRAMs: the read captures the old word before the byte writes land.
    logic [31:0] ram1 [WORDS];
    logic [31:0] ram3 [WORDS];
    logic [31:0] rd1, p0, p1, p2;

    always @(posedge clk) begin
        if (b1.mem_en) begin
            rd1 <= ram1[b1.mem_addr];
            for (int b = 0; b < 4; b++)
                if (b1.mem_we[b]) ram1[b1.mem_addr][8*b +: 8] = b1.mem_wdata[8*b +: 8];
        end
        if (b3.mem_en) begin
            p0 <= ram3[b3.mem_addr];
            for (int b = 0; b < 4; b++)
                if (b3.mem_we[b]) ram3[b3.mem_addr][8*b +: 8] = b3.mem_wdata[8*b +: 8];
        end
        p1 <= p0;
        p2 <= p1;
    end
    assign b1.mem_rdata = rd1;
    assign b3.mem_rdata = p2;

    function automatic logic [31:0] pat(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0003);
    endfunction

    function automatic int pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    typedef struct { int due; int ch; logic [31:0] data; } rsp_t;
    rsp_t        q[$];
    logic [31:0] m_mem [WORDS];
    logic [31:0] exp_rd [N];
    logic [N-1:0] exp_err, ev;
    logic [AW-1:0] ma;
    logic [31:0] old;
    int m_last = N - 1, cyc = 0, n_cmp = 0, n_bad = 0, g, eg;
    int cnt [N] = '{default: 0};
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: accepted access returns the pre-access word READ_LATENCY+1 cycles later.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_last  = N - 1;
            exp_err = '0;
        end else begin
            g = pick(m_last, b1.req_valid);
            if (g >= 0) begin
                ma  = b1.req_addr[g*AW +: AW];
                old = m_mem[ma >> 2];
                if (b1.req_we[g])
                    for (int b = 0; b < 4; b++)
                        if (b1.req_be[g*4 + b]) m_mem[ma >> 2][8*b +: 8] = b1.req_wdata[g*DW + 8*b +: 8];
                q.push_back('{cyc + 2, g, old});
                if (ma[1:0] != 2'b00) exp_err[g] = 1'b1;
                m_last = g;
            end
        end
    end

    always @(negedge clk) if (chk_on) begin
        eg = pick(m_last, b1.req_valid);
        chk("req_ready", b1.req_ready, eg >= 0 ? 2'b01 << eg : 2'b00);
        chk("mem_en", b1.mem_en, eg >= 0);
        if (eg >= 0) begin
            chk("mem_addr", b1.mem_addr, b1.req_addr[eg*AW +: AW] >> 2);
            chk("mem_we", b1.mem_we, b1.req_we[eg] ? b1.req_be[eg*4 +: 4] : 4'h0);
            if (b1.req_we[eg]) chk("mem_wdata", b1.mem_wdata, b1.req_wdata[eg*DW +: DW]);
        end else
            chk("mem_we_idle", b1.mem_we, 4'h0);
        ev = '0;
        if (!reset)
            for (int c = 0; c < N; c++) exp_rd[c] = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev[q[0].ch]     = 1'b1;
            exp_rd[q[0].ch] = q[0].data;
            void'(q.pop_front());
        end
        chk("rsp_valid", b1.rsp_valid, ev);
        for (int c = 0; c < N; c++) begin
            chk($sformatf("rsp_rdata%0d", c), b1.rsp_rdata[c*DW +: DW], exp_rd[c]);
            cnt[c] += int'(b1.rsp_valid[c]);
        end
        chk("misalign_err", b1.misalign_err, exp_err);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic we, input logic [3:0] be, input logic [15:0] a,
                          input logic [31:0] d);
        b1.req_valid[c]          = 1'b1;
        b1.req_we[c]             = we;
        b1.req_be[c*4 +: 4]      = be;
        b1.req_addr[c*AW +: AW]  = a;
        b1.req_wdata[c*DW +: DW] = d;
    endtask

    int c0, c1;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < WORDS; i++) begin
            ram1[i]  = pat(i);
            ram3[i]  = pat(i);
            m_mem[i] = pat(i);
        end
        ram1[2] = 32'hDEAD_BEEF;  m_mem[2] = 32'hDEAD_BEEF;
        ram1[4] = 32'hAAAA_AAAA;  m_mem[4] = 32'hAAAA_AAAA;
        {b1.req_valid, b1.req_we, b1.req_be, b1.req_addr, b1.req_wdata} = '0;
        {b3.req_valid, b3.req_we, b3.req_be, b3.req_addr, b3.req_wdata} = '0;
        #1 reset = 1'b0;
        b1.req_valid = 2'b11;
        #1 chk_on = 1'b1;
        chk("reset_ready", b1.req_ready, 2'b01);
        repeat (2) tick();
        b1.req_valid = '0;
        reset = 1'b1;
        tick();
        chk("post_reset_rsp", b1.rsp_valid, 2'b00);
        chk("post_reset_err", b1.misalign_err, 2'b00);
        tick();
        // single read of word 2
        set_ch(0, 1'b0, 4'h0, 16'h0008, 32'h0);
        #1 chk("read_addr", b1.mem_addr, 14'd2);
        tick();
        b1.req_valid = '0;
        tick();
        chk("read_rsp", b1.rsp_valid, 2'b01);
        chk("read_data", b1.rsp_rdata[31:0], 32'hDEAD_BEEF);
        tick();
        chk("read_pulse_end", b1.rsp_valid, 2'b00);
        chk("read_hold", b1.rsp_rdata[31:0], 32'hDEAD_BEEF);
        // write then back-to-back read of the same word
        set_ch(1, 1'b1, 4'b0011, 16'h0010, 32'h1234_5678);
        tick();
        set_ch(1, 1'b0, 4'h0, 16'h0010, 32'h0);
        tick();
        b1.req_valid = '0;
        chk("wr_rsp", b1.rsp_valid, 2'b10);
        chk("wr_old", b1.rsp_rdata[63:32], 32'hAAAA_AAAA);
        tick();
        chk("raw_rsp", b1.rsp_valid, 2'b10);
        chk("raw_data", b1.rsp_rdata[63:32], 32'hAAAA_5678);
        tick();
        // fairness: both channels request continuously
        c0 = cnt[0];
        c1 = cnt[1];
        for (int k = 0; k < 8; k++) begin
            set_ch(0, 1'b0, 4'h0, 16'(16'h0100 + 4 * k), 32'h0);
            set_ch(1, 1'b0, 4'h0, 16'(16'h0200 + 4 * k), 32'h0);
            #1 chk($sformatf("fair_grant%0d", k), b1.req_ready, k % 2 == 0 ? 2'b01 : 2'b10);
            tick();
        end
        b1.req_valid = '0;
        repeat (3) tick();
        chk("fair_cnt0", 64'(cnt[0] - c0), 64'd4);
        chk("fair_cnt1", 64'(cnt[1] - c1), 64'd4);
        // misaligned read on the latency-1 instance
        set_ch(1, 1'b0, 4'h0, 16'h0013, 32'h0);
        #1 chk("mis_addr", b1.mem_addr, 14'd4);
        tick();
        b1.req_valid = '0;
        chk("mis_err", b1.misalign_err, 2'b10);
        tick();
        chk("mis_rsp", b1.rsp_valid, 2'b10);
        chk("mis_data", b1.rsp_rdata[63:32], 32'hAAAA_5678);
        tick();
        // READ_LATENCY = 3: misaligned read and response timing
        b3.req_valid = 2'b01;
        b3.req_addr  = 32'h0000_0007;
        #1 chk("rl3_addr", b3.mem_addr, 14'd1);
        tick();
        b3.req_valid = '0;
        chk("rl3_err", b3.misalign_err, 2'b01);
        for (int j = 1; j <= 5; j++) begin
            chk($sformatf("rl3_rsp%0d", j), b3.rsp_valid, j == 4 ? 2'b01 : 2'b00);
            if (j == 4) chk("rl3_data", b3.rsp_rdata[31:0], pat(1));
            tick();
        end
        chk("rl3_err_sticky", b3.misalign_err, 2'b01);
        // reset while a ch1 read is in flight
        set_ch(1, 1'b0, 4'h0, 16'h0008, 32'h0);
        tick();
        b1.req_valid = '0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("flush_rsp%0d", j), b1.rsp_valid, 2'b00);
            tick();
        end
        set_ch(0, 1'b0, 4'h0, 16'h0020, 32'h0);
        set_ch(1, 1'b0, 4'h0, 16'h0024, 32'h0);
        #1 chk("post_flush_grant", b1.req_ready, 2'b01);
        tick();
        b1.req_valid = '0;
        repeat (4) tick();
        chk("drain", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/kuuga_bram_arbiter.md
# kuuga_bram_arbiter

Parametrised shared-memory port for the Kuuga core: NUM_CH requester channels arbitrate round-robin for one single-port block RAM (read-first, fixed read latency). Converts byte addresses to word addresses, issues one access per cycle, and routes each read/write response back to its requester through a channel-tag pipeline. It sits between the core's instruction/data BRAM ports (and debug or trace masters) and a single `xpm_memory_spram` instance, replacing one-BRAM-per-port wiring.

## Interface
- NUM_CH, 2: number of requester channels (1..8).
- ADDR_WIDTH, 16: byte-address width per channel.
- DATA_WIDTH, 32: data width; multiple of 8.
- READ_LATENCY, 1: BRAM read latency in cycles (1..4); must match the memory instance.
- Derived: BE_W = DATA_WIDTH/8; WA_W = ADDR_WIDTH - clog2(BE_W); CH_W = max(1, clog2(NUM_CH)).

- clk  in  1  single clock for all logic and the BRAM.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_CH  request present, per channel.
- req_ready  out  NUM_CH  request accepted this cycle (one-hot or zero).
- req_we  in  NUM_CH  1 = write, 0 = read.
- req_be  in  NUM_CH*BE_W  byte enables (writes only); channel i at [i*BE_W +: BE_W].
- req_addr  in  NUM_CH*ADDR_WIDTH  byte address.
- req_wdata  in  NUM_CH*DATA_WIDTH  write data.
- rsp_valid  out  NUM_CH  one-cycle response pulse.
- rsp_rdata  out  NUM_CH*DATA_WIDTH  read data (write: pre-write word), held until the next response on that channel.
- misalign_err  out  NUM_CH  sticky; set when an accepted address has nonzero low clog2(BE_W) bits.
- mem_en  out  1  BRAM enable.
- mem_we  out  BE_W  BRAM byte write enables.
- mem_addr  out  WA_W  word address = req_addr >> clog2(BE_W).
- mem_wdata  out  DATA_WIDTH  write data.
- mem_rdata  in  DATA_WIDTH  BRAM read data.

## Operation
- Arbiter: round-robin pointer `last` (CH_W bits). Priority order: last+1, last+2, ..., last (mod NUM_CH). Grant = first channel with req_valid high. req_ready = grant, combinational from req_valid and `last`.
- On accept, `last` <= granted index. No request pending: `last` unchanged, mem_en = 0, mem_we = 0.
- Memory side combinational from grant: mem_en = |grant; mem_we = req_be of winner if req_we else 0; mem_addr/mem_wdata from winner. When idle, mem_addr/mem_wdata are don't-care, mem_we = 0.
- Tag pipeline: READ_LATENCY+1 stages of {valid, channel}. Stage 0 loaded on accept. Every accepted access, read or write, produces exactly one response.
- Final stage: rsp_valid[ch] <= 1 for one cycle; rsp_rdata[ch] <= mem_rdata. Other channels' rsp_rdata unchanged.
- No response backpressure; requesters must accept rsp_valid when it pulses.
- Requests are in order per channel and globally; a channel may have up to READ_LATENCY+1 accesses in flight.
- misalign_err[i] sets on accept of channel i with misaligned address; the access still proceeds using truncated word address. It is cleared only by reset.
- NUM_CH = 1: arbiter degenerates to req_ready = req_valid.

## Timing
- Reset (asynchronous, reset low): `last` = NUM_CH-1, so channel 0 has priority first. Tag valids = 0, rsp_valid = 0, rsp_rdata = 0, misalign_err = 0. Combinational outputs follow inputs with `last` at its reset value. mem_en is combinational, so gate req_valid externally while reset is low.
- Accept at rising edge ending cycle t: BRAM samples at that edge. mem_rdata is valid in cycle t+READ_LATENCY. rsp_valid/rsp_rdata are registered and visible in cycle t+READ_LATENCY+1. Total latency = READ_LATENCY+1.
- Throughput: one access per cycle sustained. All channels requesting continuously get grants 0,1,...,NUM_CH-1,0,...
- Reset asserted mid-operation: all in-flight responses are discarded. No rsp_valid pulses after reset release for accesses accepted before reset.
- Read-after-write, same word, back-to-back cycles: the read returns the new data (BRAM read-first applies only within the same access).

## Test plan
- Reset: hold reset low, drive all req_valid = 1 -> req_ready = 01 (NUM_CH=2). After release, rsp_valid = 0 and misalign_err = 0 until the first access completes.
- Single read: ch0 reads byte addr 0x0008 with BRAM word 2 = 0xDEADBEEF, READ_LATENCY=1 -> mem_addr = 2 in the accept cycle. rsp_valid[0] pulses 2 cycles later with rsp_rdata[0] = 0xDEADBEEF, and the value holds afterwards.
- Write then read: ch1 writes 0x12345678 to 0x0010 with be=4'b0011 (old word 0xAAAAAAAA), then reads it -> write response rdata = 0xAAAAAAAA; read response = 0xAAAA5678.
- Fairness: both channels request for 8 cycles -> grants alternate 0,1,0,1,... Each channel receives 4 responses, in order, with rsp_valid never high on both channels in the same cycle.
- Misaligned and latency: READ_LATENCY=3, ch0 reads 0x0007 -> mem_addr = 1, misalign_err[0] = 1 (sticky). rsp_valid[0] pulses 4 cycles after accept.
- Reset mid-flight: accept a ch1 read, assert reset the next cycle, release -> no rsp_valid[1] pulse, and the next grant with both channels requesting goes to ch0.
